// File: rtl/mac_requant.sv
// Two-stage requantizer: S1 multiplies accumulator by scale, S2 rounds/shifts/offsets/saturates.
// Optional MAC_REQUANT_RELU_EN clamps negative shifted values to zero before the offset add.
module mac_requant #(
    parameter int ACC_W  = 21,
    parameter int OUT_W  = 8,
    parameter int MULT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ACC_W-1:0]  acc_in,
    input  logic              acc_valid,
    output logic              acc_ready,
    input  logic [MULT_W-1:0] mult,
    input  logic [4:0]        shift,
    input  logic [OUT_W-1:0]  zero_point,
    output logic [OUT_W-1:0]  q_out,
    output logic              q_valid,
    input  logic              q_ready,
    output logic [15:0]       sat_count,
    input  logic              cnt_clr
);
    localparam int PROD_W = ACC_W + MULT_W + 1;
    localparam int RND_W  = PROD_W + 1;
    localparam int SUM_W  = RND_W + 1;

    localparam logic signed [SUM_W-1:0] Q_MAX = SUM_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [SUM_W-1:0] Q_MIN = ~Q_MAX;

    logic                     s1_vld_q, s1_vld_d;
    logic signed [PROD_W-1:0] prod_q, prod_d;
    logic [4:0]               shift_q, shift_d;
    logic [OUT_W-1:0]         zp_q, zp_d;
    logic                     q_valid_q, q_valid_d;
    logic [OUT_W-1:0]         q_out_q, q_out_d;
    logic [15:0]              sat_cnt_q, sat_cnt_d;

    logic                     q_stall, s1_adv, acc_fire;
    logic signed [PROD_W-1:0] acc_ext, mult_ext;
    logic signed [RND_W-1:0]  rnd, shifted;
    logic signed [SUM_W-1:0]  sum;
    logic                     sat;
    logic [OUT_W-1:0]         res;

    // Handshake: a stage moves only when the one after it is empty or draining.
    always_comb begin
        q_stall   = q_valid_q & ~q_ready;
        s1_adv    = s1_vld_q & ~q_stall;
        acc_ready = ~s1_vld_q | s1_adv;
        acc_fire  = acc_valid & acc_ready;
    end

    // S1: signed accumulator times unsigned scale; both operands widened to the product width.
    always_comb begin
        acc_ext  = {{(PROD_W-ACC_W){acc_in[ACC_W-1]}}, acc_in};
        mult_ext = {{(PROD_W-MULT_W){1'b0}}, mult};
        prod_d   = prod_q;
        shift_d  = shift_q;
        zp_d     = zp_q;
        s1_vld_d = acc_fire | (s1_vld_q & ~s1_adv);
        if (acc_fire) begin
            prod_d  = acc_ext * mult_ext;
            shift_d = shift;
            zp_d    = zero_point;
        end
    end

    // S2: round half toward +inf, arithmetic shift, offset, clamp.
    always_comb begin
        rnd = {prod_q[PROD_W-1], prod_q};
        if (shift_q != 5'd0)
            rnd = rnd + ({{(RND_W-1){1'b0}}, 1'b1} << (shift_q - 5'd1));
        shifted = rnd >>> shift_q;
`ifdef MAC_REQUANT_RELU_EN
        if (shifted < 0)
            shifted = '0;
`endif
        sum = {shifted[RND_W-1], shifted} + {{(SUM_W-OUT_W){zp_q[OUT_W-1]}}, zp_q};
        sat = 1'b0;
        res = sum[OUT_W-1:0];
        if (sum > Q_MAX) begin
            sat = 1'b1;
            res = Q_MAX[OUT_W-1:0];
        end else if (sum < Q_MIN) begin
            sat = 1'b1;
            res = Q_MIN[OUT_W-1:0];
        end
    end

    always_comb begin
        q_valid_d = s1_adv | q_stall;
        q_out_d   = s1_adv ? res : q_out_q;
        sat_cnt_d = sat_cnt_q;
        if (cnt_clr)
            sat_cnt_d = '0;
        else if (s1_adv && sat && sat_cnt_q != 16'hFFFF)
            sat_cnt_d = sat_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            prod_q    <= '0;
            shift_q   <= '0;
            zp_q      <= '0;
            q_valid_q <= 1'b0;
            q_out_q   <= '0;
            sat_cnt_q <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            prod_q    <= prod_d;
            shift_q   <= shift_d;
            zp_q      <= zp_d;
            q_valid_q <= q_valid_d;
            q_out_q   <= q_out_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign q_out     = q_out_q;
    assign q_valid   = q_valid_q;
    assign sat_count = sat_cnt_q;
endmodule

// File: tb/tb_mac_requant.sv
// Bench for mac_requant: arithmetic reference model with an expected-output queue,
// plus directed vectors for latency, stalls, saturation counting and reset flush.
module tb_mac_requant;
    localparam int ACC_W  = 21;
    localparam int OUT_W  = 8;
    localparam int MULT_W = 8;
    localparam longint QMAX = (64'sd1 <<< (OUT_W - 1)) - 1;
    localparam longint QMIN = -(64'sd1 <<< (OUT_W - 1));

    logic              clk, rst;
    logic [ACC_W-1:0]  acc_in;
    logic              acc_valid, acc_ready;
    logic [MULT_W-1:0] mult;
    logic [4:0]        shift;
    logic [OUT_W-1:0]  zero_point;
    logic [OUT_W-1:0]  q_out;
    logic              q_valid, q_ready;
    logic [15:0]       sat_count;
    logic              cnt_clr;

    mac_requant #(.ACC_W(ACC_W), .OUT_W(OUT_W), .MULT_W(MULT_W)) dut (
        .clk(clk), .rst(rst), .acc_in(acc_in), .acc_valid(acc_valid), .acc_ready(acc_ready),
        .mult(mult), .shift(shift), .zero_point(zero_point), .q_out(q_out), .q_valid(q_valid),
        .q_ready(q_ready), .sat_count(sat_count), .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;
    int  q_exp[$];
    int  sat_exp = 0;
    int  stall_hits = 0;
    bit  hold_prev = 0;
    int  prev_q = 0;
    int  mon_e;
    bit  mon_s;
    bit  pin_s;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: exact integer arithmetic on the requantization rules.
    function automatic int model(input int acc, input int m, input int sh, input int zp, output bit sat);
        longint p;
        p = longint'(acc) * longint'(m);
        if (sh > 0)
            p = p + (longint'(1) <<< (sh - 1));
        p = p >>> sh;
`ifdef MAC_REQUANT_RELU_EN
        if (p < 0) p = 0;
`endif
        p = p + zp;
        sat = 1'b0;
        if (p > QMAX) begin p = QMAX; sat = 1'b1; end
        else if (p < QMIN) begin p = QMIN; sat = 1'b1; end
        return int'(p);
    endfunction

    // Compare process: all handshakes observed at negedge, where inputs and outputs are settled.
    always @(negedge clk) begin
        if (rst) begin
            q_exp.delete();
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", int'(q_valid), 1);
                chk("hold_data", int'($signed(q_out)), prev_q);
            end
            if (cnt_clr) sat_exp = 0;
            if (acc_valid && acc_ready) begin
                mon_e = model(int'($signed(acc_in)), int'(mult), int'(shift), int'($signed(zero_point)), mon_s);
                q_exp.push_back(mon_e);
                if (mon_s && sat_exp != 65535) sat_exp++;
            end
            if (acc_valid && !acc_ready) stall_hits++;
            if (q_valid && q_ready) begin
                if (q_exp.size() == 0) chk("unexpected_out", int'($signed(q_out)), 9999);
                else chk("q_out", int'($signed(q_out)), q_exp.pop_front());
            end
            hold_prev = q_valid && !q_ready;
            prev_q    = int'($signed(q_out));
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input int a, input int m, input int sh, input int zp);
        acc_in     = ACC_W'(a);
        mult       = MULT_W'(m);
        shift      = 5'(sh);
        zero_point = OUT_W'(zp);
        acc_valid  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (acc_ready) begin
                @(posedge clk); #1;
                acc_valid = 1'b0;
                return;
            end
        end
        chk("send_timeout", 0, 1);
        acc_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (q_exp.size() == 0 && !q_valid) begin
                @(posedge clk); #1;
                return;
            end
        end
        chk("drain_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 0; rst = 1; acc_in = '0; acc_valid = 0; mult = '0; shift = '0;
        zero_point = '0; q_ready = 1; cnt_clr = 0;

        // Model pins against hand-computed values
        chk("pin_53", model(100, 128, 8, 3, pin_s), 53);
        chk("pin_rnd_pos", model(3, 1, 1, 0, pin_s), 2);
        chk("pin_rnd_neg", model(-3, 1, 1, 0, pin_s), -1);
        chk("pin_sat_hi", model(1000, 64, 8, 0, pin_s), 127);
        chk("pin_sat_hi_flag", int'(pin_s), 1);
        chk("pin_sat_lo", model(-100000, 255, 0, 0, pin_s), -128);
`ifdef MAC_REQUANT_RELU_EN
        chk("pin_relu", model(-50, 1, 0, 5, pin_s), 5);
`else
        chk("pin_norelu", model(-50, 1, 0, 5, pin_s), -45);
`endif

        repeat (2) @(negedge clk);
        chk("rst_q_valid", int'(q_valid), 0);
        chk("rst_q_out", int'(q_out), 0);
        chk("rst_sat_count", int'(sat_count), 0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("idle_acc_ready", int'(acc_ready), 1);
        @(posedge clk); #1;

        // Latency: q_valid two cycles after presentation
        send(100, 128, 8, 3);
        chk("lat_s1_only", int'(q_valid), 0);
        @(posedge clk); #1;
        chk("lat_q_valid", int'(q_valid), 1);
        chk("lat_q_out", int'($signed(q_out)), 53);
        drain();
        chk("sat_after_53", int'(sat_count), 0);

        send(3, 1, 1, 0);
        send(-3, 1, 1, 0);
        drain();

        send(1000, 64, 8, 0);
        drain();
        chk("sat_one", int'(sat_count), 1);
        send(-100000, 255, 0, 0);
        drain();
        chk("sat_two", int'(sat_count), 2);

        send(-50, 1, 0, 5);
        drain();
        chk("relu_no_sat", int'(sat_count), 2);

        // Large shifts collapse the magnitude to 0 before the offset
        send(-1048576, 255, 31, 0);
        send(-5, 1, 29, 0);
        send(1048575, 255, 29, -128);
        send(-7, 3, 0, 127);
        drain();
        chk("sat_model", int'(sat_count), sat_exp);

        // Mid-stream backpressure
        stall_hits = 0;
        fork
            begin
                for (int v = 1; v <= 5; v++) send(v, 1, 0, 0);
            end
            begin
                repeat (2) @(posedge clk);
                #1 q_ready = 0;
                repeat (3) @(posedge clk);
                #1 q_ready = 1;
            end
        join
        drain();
        chk("acc_ready_dropped", int'(stall_hits > 0), 1);

        cnt_clr = 1;
        @(posedge clk); #1 cnt_clr = 0;
        chk("clr", int'(sat_count), 0);

        // Clear on the same edge a saturating beat lands in the output register
        send(1000, 64, 8, 0);
        cnt_clr = 1;
        @(posedge clk); #1 cnt_clr = 0;
        chk("clr_priority", int'(sat_count), 0);
        drain();
        chk("clr_priority_after", int'(sat_count), sat_exp);

        // Reset with two beats held in flight
        q_ready = 0;
        send(10, 1, 0, 0);
        send(20, 1, 0, 0);
        rst = 1;
        @(negedge clk);
        chk("mid_rst_q_valid", int'(q_valid), 0);
        chk("mid_rst_q_out", int'(q_out), 0);
        @(posedge clk); #1;
        rst = 0; q_ready = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", int'(q_valid), 0);
        end
        chk("post_rst_ready", int'(acc_ready), 1);
        @(posedge clk); #1;

        // Counter sticks at all-ones
        acc_in = ACC_W'(1000); mult = MULT_W'(64); shift = 5'd8; zero_point = '0;
        acc_valid = 1;
        repeat (65540) @(posedge clk);
        #1 acc_valid = 0;
        drain();
        chk("sat_sticky", int'(sat_count), 65535);
        chk("sat_sticky_model", int'(sat_count), sat_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
